// File: rtl/lsu_sequencer_if.sv
// Core request/response channel and word-aligned memory bus of the LSU sequencer.
// slave is the sequencer's view; master is the core/memory environment's view.
interface lsu_sequencer_if #(
   parameter int DWIDTH = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [DWIDTH-1:0] req_addr;
   logic [DWIDTH-1:0] req_wdata;
   logic              rsp_valid;
   logic [DWIDTH-1:0] rsp_rdata;
   logic              rsp_err;
   logic              mem_req;
   logic              mem_gnt;
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [DWIDTH-1:0] mem_addr;
   logic [DWIDTH-1:0] mem_wdata;
   logic              mem_rvalid;
   logic [DWIDTH-1:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );
endinterface

// File: rtl/lsu_sequencer.sv
// RV32I load/store sequencer: byte/half/word requests become word-aligned bus beats.
// Define LSU_MISALIGN_SPLIT_EN to serve word-crossing accesses with two beats instead of an error.
module lsu_sequencer #(
   parameter int DWIDTH = 32
) (
   input logic            clk,
   input logic            rst,
   lsu_sequencer_if.slave bus
);

   if (DWIDTH != 32) begin : g_width_check
      $error("lsu_sequencer: DWIDTH must be 32");
   end

   typedef enum logic [2:0] {StIdle, StReq1, StWait1, StReq2, StWait2, StResp} state_t;

   state_t      state_q, state_d;
   logic        we_q, err_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q, wdata_q;
   logic [63:0] raw_q;  // beat 1 in [31:0], beat 2 in [63:32]

   function automatic logic legal_f3(input logic we, input logic [2:0] f3);
      if (we) return f3 inside {3'b000, 3'b001, 3'b010};
      return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
   endfunction

   function automatic logic crosses(input logic [2:0] f3, input logic [1:0] off);
      logic [2:0] size;
      size = 3'd1 << f3[1:0];
      return ({1'b0, off} + size) > 3'd4;
   endfunction

   logic accept, accept_err;
   assign accept = (state_q == StIdle) && bus.req_valid;
`ifdef LSU_MISALIGN_SPLIT_EN
   assign accept_err = !legal_f3(bus.req_we, bus.req_funct3);
`else
   assign accept_err = !legal_f3(bus.req_we, bus.req_funct3) ||
                       crosses(bus.req_funct3, bus.req_addr[1:0]);
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.req_valid) state_d = accept_err ? StResp : StReq1;
         StReq1:  if (bus.mem_gnt) state_d = StWait1;
         StWait1: begin
            if (bus.mem_rvalid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
               state_d = crosses(funct3_q, addr_q[1:0]) ? StReq2 : StResp;
`else
               state_d = StResp;
`endif
            end
         end
         StReq2:  if (bus.mem_gnt) state_d = StWait2;
         StWait2: if (bus.mem_rvalid) state_d = StResp;
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= '0;
         wdata_q  <= '0;
         raw_q    <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q     <= bus.req_we;
            err_q    <= accept_err;
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            raw_q    <= '0;
         end
         if (state_q == StWait1 && bus.mem_rvalid) raw_q[31:0] <= bus.mem_rdata;
         if (state_q == StWait2 && bus.mem_rvalid) raw_q[63:32] <= bus.mem_rdata;
      end
   end

   logic        second;
   logic [3:0]  be_base;
   logic [7:0]  be_wide;
   logic [63:0] wdata_wide;
   logic [31:0] ld_word;

   assign second = (state_q == StReq2);

   always_comb begin
      case (funct3_q[1:0])
         2'b00:   be_base = 4'b0001;
         2'b01:   be_base = 4'b0011;
         default: be_base = 4'b1111;
      endcase
   end

   // Lanes past byte 3 spill into the upper half and belong to the second beat.
   assign be_wide    = {4'b0000, be_base} << addr_q[1:0];
   assign wdata_wide = {32'h0, wdata_q} << {addr_q[1:0], 3'b000};
   assign ld_word    = 32'(raw_q >> {addr_q[1:0], 3'b000});

   always_comb begin
      bus.req_ready = (state_q == StIdle);
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_be    = 4'b0000;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.rsp_valid = 1'b0;
      bus.rsp_err   = 1'b0;
      bus.rsp_rdata = '0;
      if (state_q == StReq1 || state_q == StReq2) begin
         bus.mem_req   = 1'b1;
         bus.mem_we    = we_q;
         bus.mem_be    = second ? be_wide[7:4] : be_wide[3:0];
         bus.mem_addr  = {addr_q[31:2], 2'b00} + (second ? 32'd4 : 32'd0);
         bus.mem_wdata = we_q ? (second ? wdata_wide[63:32] : wdata_wide[31:0]) : 32'h0;
      end
      if (state_q == StResp) begin
         bus.rsp_valid = 1'b1;
         bus.rsp_err   = err_q;
         if (!err_q && !we_q) begin
            case (funct3_q)
               3'b000:  bus.rsp_rdata = {{24{ld_word[7]}}, ld_word[7:0]};
               3'b001:  bus.rsp_rdata = {{16{ld_word[15]}}, ld_word[15:0]};
               3'b100:  bus.rsp_rdata = {24'h0, ld_word[7:0]};
               3'b101:  bus.rsp_rdata = {16'h0, ld_word[15:0]};
               default: bus.rsp_rdata = ld_word;
            endcase
         end
      end
   end

endmodule
